// File: rtl/barrel_shifter_pipe_if.sv
// barrel_shifter_pipe_if: operand (in_*) and result (out_*) valid/ready channels of barrel_shifter_pipe
//   master: the datapath source/consumer side; drives operands and out_ready
//   slave:  the shift unit; drives in_ready and the result fields
interface barrel_shifter_pipe_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
);
    localparam int SHAMT_W = $clog2(WIDTH);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic [SHAMT_W-1:0] in_amt;
    logic [2:0]         in_mode;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_y;
    logic [TAG_W-1:0]   out_tag;
    logic               out_zero;
    logic               out_err;
    modport master (
        output in_valid, in_a, in_amt, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_y, out_tag, out_zero, out_err
    );
    modport slave (
        input  in_valid, in_a, in_amt, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_y, out_tag, out_zero, out_err
    );
endinterface

// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe: pipelined SLL/SRL/SRA/ROL/ROR unit, one log2 shift stage per register, valid/ready flow
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : slave side of barrel_shifter_pipe_if (operand in, result out, tag sideband)
module barrel_shifter_pipe #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input logic                  clk,
    input logic                  reset,
    barrel_shifter_pipe_if.slave bus
);
    localparam int SHAMT_W = $clog2(WIDTH);
    localparam logic [2:0] SRL = 3'd1, SRA = 3'd2, ROL = 3'd3, ROR = 3'd4;
    typedef struct packed {
        logic               v;
        logic [WIDTH-1:0]   d;
        logic [SHAMT_W-1:0] amt;
        logic [2:0]         mode;
        logic [TAG_W-1:0]   tag;
        logic               fill;
    } stage_t;
    stage_t st [SHAMT_W];
    stage_t nx [SHAMT_W];
    stage_t ent;
    logic   advance;
    function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = x[WIDTH-1-i];
        return r;
    endfunction
    function automatic logic right(input logic [2:0] m);
        return m == SRL || m == SRA || m == ROR;
    endfunction
    // Every mode shifts left; right-type operands are bit-reversed around the pipe.
    // Illegal modes never shift, so the operand passes through untouched.
    function automatic stage_t step(input stage_t s, input int k);
        stage_t           r;
        logic [WIDTH-1:0] fill_bits;
        r = s;
        fill_bits = s.fill ? ~({WIDTH{1'b1}} << (1 << k)) : '0;
        if (s.amt[k] && s.mode <= ROR)
            r.d = (s.mode == ROL || s.mode == ROR) ? (s.d << (1 << k)) | (s.d >> (WIDTH - (1 << k)))
                                                   : (s.d << (1 << k)) | fill_bits;
        return r;
    endfunction
    assign advance      = ~bus.out_valid | bus.out_ready;
    assign bus.in_ready = advance;
    always_comb begin
        ent.v    = bus.in_valid;
        ent.d    = right(bus.in_mode) ? rev(bus.in_a) : bus.in_a;
        ent.amt  = bus.in_amt;
        ent.mode = bus.in_mode;
        ent.tag  = bus.in_tag;
        // SRA sign lands in the low bits after reversal, so the fill is taken from the original MSB
        ent.fill = (bus.in_mode == SRA) & bus.in_a[WIDTH-1];
        nx[0]    = step(ent, 0);
        for (int k = 1; k < SHAMT_W; k++) nx[k] = step(st[k-1], k);
    end
    always_ff @(posedge clk) begin
        if (reset)
            for (int k = 0; k < SHAMT_W; k++) st[k] <= '0;
        else if (advance)
            for (int k = 0; k < SHAMT_W; k++) st[k] <= nx[k];
    end
    assign bus.out_valid = st[SHAMT_W-1].v;
    assign bus.out_y     = right(st[SHAMT_W-1].mode) ? rev(st[SHAMT_W-1].d) : st[SHAMT_W-1].d;
    assign bus.out_tag   = st[SHAMT_W-1].tag;
    assign bus.out_zero  = st[SHAMT_W-1].v & (bus.out_y == '0);
    assign bus.out_err   = st[SHAMT_W-1].v & (st[SHAMT_W-1].mode > ROR);
endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// tb_barrel_shifter_pipe: directed and randomized checks of barrel_shifter_pipe against a behavioural model
module tb_barrel_shifter_pipe;
    logic clk = 0;
    logic reset = 1;
    int   n_chk = 0;
    int   n_fail = 0;
    logic done = 0;
    typedef struct {
        logic [15:0] y;
        logic [3:0]  tag;
        logic        err;
    } exp_t;
    exp_t q[$];
    logic [15:0] s_a;
    logic [3:0]  s_n;
    logic [2:0]  s_m;
    int          lat;
    logic [15:0] da [8] = '{16'h8001, 16'h8000, 16'hF000, 16'h0001, 16'h8001, 16'h0001, 16'h1234, 16'h8000};
    logic [3:0]  dn [8] = '{4'd1, 4'd4, 4'd15, 4'd1, 4'd4, 4'd1, 4'd5, 4'd0};
    logic [2:0]  dm [8] = '{3'd0, 3'd2, 3'd1, 3'd1, 3'd3, 3'd4, 3'd6, 3'd2};
    logic [3:0]  dt [8] = '{4'd3, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    logic [15:0] dy [8] = '{16'h0002, 16'hF800, 16'h0001, 16'h0000, 16'h0018, 16'h8000, 16'h1234, 16'h8000};
    barrel_shifter_pipe_if #(.WIDTH(16), .TAG_W(4)) bus();
    barrel_shifter_pipe #(.WIDTH(16), .TAG_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    function automatic logic [15:0] model(input logic [15:0] a, input int amt, input logic [2:0] mode);
        logic [31:0] w;
        case (mode)
            3'd0: return a << amt;
            3'd1: return a >> amt;
            3'd2: return $signed(a) >>> amt;
            3'd3: begin w = {a, a} << amt; return w[31:16]; end
            3'd4: begin w = {a, a} >> amt; return w[15:0]; end
            default: return a;
        endcase
    endfunction
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic send(input logic [15:0] a, input logic [3:0] amt, input logic [2:0] mode, input logic [3:0] tag);
        int   n = 0;
        logic ok;
        bus.in_valid = 1;
        bus.in_a     = a;
        bus.in_amt   = amt;
        bus.in_mode  = mode;
        bus.in_tag   = tag;
        do begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 200);
        check("accepted", ok, 1);
    endtask
    task automatic drain();
        int n = 0;
        bus.out_ready = 1;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_queue_empty", q.size(), 0);
    endtask
    always @(negedge clk) begin
        exp_t e;
        if (reset) q.delete();
        else begin
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) check("queue_depth_at_output", q.size(), 1);
                else begin
                    e = q.pop_front();
                    check("out_y", bus.out_y, e.y);
                    check("out_tag", bus.out_tag, e.tag);
                    check("out_err", bus.out_err, e.err);
                    check("out_zero", bus.out_zero, e.y == 16'h0);
                end
            end
            if (bus.in_valid && bus.in_ready)
                q.push_back('{model(bus.in_a, bus.in_amt, bus.in_mode), bus.in_tag, bus.in_mode > 3'd4});
        end
    end
    initial begin
        bus.in_valid  = 0;
        bus.in_a      = 0;
        bus.in_amt    = 0;
        bus.in_mode   = 0;
        bus.in_tag    = 0;
        bus.out_ready = 1;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_y", bus.out_y, 0);
        check("rst_out_tag", bus.out_tag, 0);
        check("rst_out_zero", bus.out_zero, 0);
        check("rst_out_err", bus.out_err, 0);
        check("rst_in_ready", bus.in_ready, 1);
        for (int i = 0; i < 8; i++) begin
            send(da[i], dn[i], dm[i], dt[i]);
            bus.in_valid = 0;
            lat = 1;
            while (!bus.out_valid && lat < 20) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check("dir_latency", lat, 4);
            check("dir_y", bus.out_y, dy[i]);
            check("dir_tag", bus.out_tag, dt[i]);
            check("dir_zero", bus.out_zero, dy[i] == 16'h0);
            check("dir_err", bus.out_err, dm[i] > 3'd4);
            repeat (2) @(posedge clk);
            #1;
        end
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(16'($urandom), 4'($urandom_range(15)), 3'($urandom_range(4)), 4'(i));
                bus.in_valid = 0;
            end
            begin
                int w = 0;
                while (!bus.out_valid && w < 50) begin
                    @(posedge clk);
                    #1;
                    w++;
                end
                for (int i = 0; i < 8; i++) begin
                    check("b2b_valid", bus.out_valid, 1);
                    check("b2b_tag", bus.out_tag, i);
                    @(posedge clk);
                    #1;
                end
                check("b2b_end_valid", bus.out_valid, 0);
            end
        join
        drain();
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    logic [15:0] a;
                    logic [3:0]  n;
                    logic [2:0]  m;
                    a = 16'($urandom);
                    n = 4'($urandom_range(1, 15));
                    m = 3'($urandom_range(4));
                    if (i == 0) begin
                        s_a = a;
                        s_n = n;
                        s_m = m;
                    end
                    send(a, n, m, 4'(8 + i));
                end
                bus.in_valid = 0;
            end
            begin
                int w = 0;
                while (!bus.out_valid && w < 50) begin
                    @(posedge clk);
                    #1;
                    w++;
                end
                bus.out_ready = 0;
                for (int j = 0; j < 5; j++) begin
                    @(negedge clk);
                    check("stall_in_ready", bus.in_ready, 0);
                    check("stall_valid", bus.out_valid, 1);
                    check("stall_tag", bus.out_tag, 8);
                    check("stall_y", bus.out_y, model(s_a, s_n, s_m));
                end
                @(posedge clk);
                #1 bus.out_ready = 1;
            end
        join
        drain();
        for (int i = 0; i < 3; i++) send(16'($urandom), 4'($urandom_range(15)), 3'd0, 4'(i));
        bus.in_valid = 0;
        reset = 1;
        @(posedge clk);
        #1 reset = 0;
        check("rst_mid_out_valid", bus.out_valid, 0);
        check("rst_mid_in_ready", bus.in_ready, 1);
        lat = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid) lat++;
        end
        check("rst_mid_stale", lat, 0);
        @(posedge clk);
        #1;
        send(16'h00F0, 4'd4, 3'd3, 4'd9);
        bus.in_valid = 0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("rst_post_latency", lat, 4);
        check("rst_post_y", bus.out_y, 16'h0F00);
        check("rst_post_tag", bus.out_tag, 9);
        drain();
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(3) == 0) begin
                        bus.in_valid = 0;
                        @(posedge clk);
                        #1;
                    end
                    send(16'($urandom), 4'($urandom_range(15)), 3'($urandom_range(7)), 4'($urandom));
                end
                bus.in_valid = 0;
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 bus.out_ready = $urandom_range(3) != 0;
                end
            end
        join
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
